// File: rtl/round_robin_stream_arbiter.sv
// round_robin_stream_arbiter: N-to-1 valid/ready stream mux with round-robin grant, optional packet lock and registered output
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   input_valid/ready/data/last    per-channel request streams (channel c data at [c*WIDTH +: WIDTH])
//   output_valid/ready/data/last   registered output stream
//   output_channel                 source channel of the current output beat
module round_robin_stream_arbiter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8,
  parameter int LOCK_PACKETS = 1,
  localparam int CW = $clog2(CHANNELS) > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       input_valid,
  output logic [CHANNELS-1:0]       input_ready,
  input  logic [CHANNELS*WIDTH-1:0] input_data,
  input  logic [CHANNELS-1:0]       input_last,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [WIDTH-1:0]          output_data,
  output logic                      output_last,
  output logic [CW-1:0]             output_channel
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [CW-1:0] ptr, locked, grant;
  logic has_grant, can_load, transfer, sel_last;
  logic [WIDTH-1:0] sel_data;
  // Descending scan so the last hit wins: that is the valid channel closest to ptr.
  always_comb begin
    grant = locked;
    has_grant = state == LOCKED;
    if (state == IDLE)
      for (int i = CHANNELS - 1; i >= 0; i--)
        if (input_valid[(int'(ptr) + i) % CHANNELS]) begin
          grant = CW'((int'(ptr) + i) % CHANNELS);
          has_grant = 1'b1;
        end
  end
  assign can_load = !output_valid || output_ready;
  assign transfer = has_grant && can_load && input_valid[grant] && !reset;
  assign input_ready = (has_grant && can_load && !reset) ? CHANNELS'(1) << grant : '0;
  assign sel_data = input_data[int'(grant) * WIDTH +: WIDTH];
  assign sel_last = input_last[grant];
  always_comb begin
    state_n = state;
    if (transfer && LOCK_PACKETS != 0) state_n = sel_last ? IDLE : LOCKED;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      locked <= '0;
      output_valid <= 1'b0;
      output_data <= '0;
      output_last <= 1'b0;
      output_channel <= '0;
    end else begin
      state <= state_n;
      if (transfer) begin
        locked <= grant;
        output_valid <= 1'b1;
        output_data <= sel_data;
        output_last <= sel_last;
        output_channel <= grant;
        if (LOCK_PACKETS == 0 || sel_last) ptr <= grant == CW'(CHANNELS - 1) ? '0 : grant + 1'b1;
      end else if (output_ready) begin
        output_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_round_robin_stream_arbiter.sv
// tb_round_robin_stream_arbiter: directed self-checking bench for locked (dut) and unlocked (dut_u) arbiters
module tb_round_robin_stream_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic [3:0] valid, ready, last;
  logic [31:0] data;
  logic out_ready, ov, ol;
  logic [7:0] od;
  logic [1:0] oc;
  logic [3:0] u_valid, u_ready, u_last;
  logic [31:0] u_data;
  logic u_out_ready, u_ov, u_ol;
  logic [7:0] u_od;
  logic [1:0] u_oc;
  int total = 0, passed = 0;

  round_robin_stream_arbiter #(.CHANNELS(4), .WIDTH(8), .LOCK_PACKETS(1)) dut (
    .clock(clock), .reset(reset), .input_valid(valid), .input_ready(ready), .input_data(data),
    .input_last(last), .output_valid(ov), .output_ready(out_ready), .output_data(od),
    .output_last(ol), .output_channel(oc));

  round_robin_stream_arbiter #(.CHANNELS(4), .WIDTH(8), .LOCK_PACKETS(0)) dut_u (
    .clock(clock), .reset(reset), .input_valid(u_valid), .input_ready(u_ready), .input_data(u_data),
    .input_last(u_last), .output_valid(u_ov), .output_ready(u_out_ready), .output_data(u_od),
    .output_last(u_ol), .output_channel(u_oc));

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    valid = 4'hF; last = 4'hF; data = 32'h03020100; out_ready = 1'b1;
    u_valid = 4'h0; u_last = 4'h0; u_data = '0; u_out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) begin
      step();
      total++;
      if (ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", ready); else passed++;
      total++;
      if ({ov, ol, oc, od} !== 12'h000) $display("FAIL reset_out got v=%b l=%b c=%0d d=%h want all 0", ov, ol, oc, od); else passed++;
    end
    reset = 1'b0;
    #1;
    total++;
    if (ready !== 4'b0001) $display("FAIL first_grant got %b want 0001", ready); else passed++;
  endtask

  task automatic test_round_robin;
    logic [1:0] ec;
    for (int k = 0; k < 8; k++) begin
      step();
      ec = 2'(k % 4);
      total++;
      if ({ov, oc, od, ol} !== {1'b1, ec, 6'd0, ec, 1'b1})
        $display("FAIL rr_beat%0d got v=%b c=%0d d=%h l=%b want v=1 c=%0d d=%h l=1", k, ov, oc, od, ol, ec, ec);
      else passed++;
      total++;
      if (ready !== 4'(1 << ((k + 1) % 4))) $display("FAIL rr_ready%0d got %b want %b", k, ready, 4'(1 << ((k + 1) % 4))); else passed++;
    end
    valid = 4'h0;
    step();
    total++;
    if (ov !== 1'b0) $display("FAIL rr_drain got %b want 0", ov); else passed++;
  endtask

  task automatic test_packet_lock;
    valid = 4'b0001;
    step();
    total++;
    if ({ov, oc} !== 3'b100) $display("FAIL lock_pre got v=%b c=%0d want v=1 c=0", ov, oc); else passed++;
    valid = 4'hF; last = 4'b1101; data = 32'h03021100;
    #1;
    total++;
    if (ready !== 4'b0010) $display("FAIL lock_grant got %b want 0010", ready); else passed++;
    step();
    total++;
    if ({oc, od, ol} !== {2'd1, 8'h11, 1'b0}) $display("FAIL lock_beat1 got c=%0d d=%h l=%b want c=1 d=11 l=0", oc, od, ol); else passed++;
    total++;
    if (ready !== 4'b0010) $display("FAIL lock_hold got %b want 0010", ready); else passed++;
    valid = 4'b1101;
    #1;
    total++;
    if (ready !== 4'b0010) $display("FAIL lock_novalid got %b want 0010", ready); else passed++;
    step();
    total++;
    if (ov !== 1'b0) $display("FAIL lock_gap got %b want 0", ov); else passed++;
    valid = 4'hF; data = 32'h03021200;
    step();
    total++;
    if ({ov, oc, od, ol} !== {1'b1, 2'd1, 8'h12, 1'b0}) $display("FAIL lock_beat2 got v=%b c=%0d d=%h l=%b want v=1 c=1 d=12 l=0", ov, oc, od, ol); else passed++;
    data = 32'h03021300; last = 4'hF;
    step();
    total++;
    if ({oc, od, ol} !== {2'd1, 8'h13, 1'b1}) $display("FAIL lock_beat3 got c=%0d d=%h l=%b want c=1 d=13 l=1", oc, od, ol); else passed++;
    total++;
    if (ready !== 4'b0100) $display("FAIL lock_release got %b want 0100", ready); else passed++;
    step();
    total++;
    if ({oc, od} !== {2'd2, 8'h02}) $display("FAIL lock_next2 got c=%0d d=%h want c=2 d=02", oc, od); else passed++;
    step();
    total++;
    if ({oc, od} !== {2'd3, 8'h03}) $display("FAIL lock_next3 got c=%0d d=%h want c=3 d=03", oc, od); else passed++;
    valid = 4'h0;
    step();
  endtask

  task automatic test_backpressure;
    data = 32'h03020100; last = 4'hF; valid = 4'hF;
    step();
    total++;
    if ({ov, oc} !== 3'b100) $display("FAIL bp_first got v=%b c=%0d want v=1 c=0", ov, oc); else passed++;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if ({ov, oc, od, ol} !== {1'b1, 2'd0, 8'h00, 1'b1}) $display("FAIL bp_hold%0d got v=%b c=%0d d=%h l=%b want v=1 c=0 d=00 l=1", k, ov, oc, od, ol); else passed++;
      total++;
      if (ready !== 4'b0000) $display("FAIL bp_ready%0d got %b want 0000", k, ready); else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (ready !== 4'b0010) $display("FAIL bp_resume got %b want 0010", ready); else passed++;
    for (int k = 1; k < 4; k++) begin
      step();
      total++;
      if ({ov, oc, od} !== {1'b1, 2'(k), 8'(k)}) $display("FAIL bp_seq%0d got v=%b c=%0d d=%h want v=1 c=%0d", k, ov, oc, od, k); else passed++;
    end
    valid = 4'h0;
    step();
    total++;
    if (ov !== 1'b0) $display("FAIL bp_drain got %b want 0", ov); else passed++;
  endtask

  task automatic test_sparse;
    valid = 4'b1000;
    #1;
    total++;
    if (ready !== 4'b1000) $display("FAIL sparse_grant3 got %b want 1000", ready); else passed++;
    step();
    total++;
    if ({oc, od} !== {2'd3, 8'h03}) $display("FAIL sparse_out3 got c=%0d d=%h want c=3 d=03", oc, od); else passed++;
    valid = 4'b0101;
    #1;
    total++;
    if (ready !== 4'b0001) $display("FAIL sparse_wrap got %b want 0001", ready); else passed++;
    step();
    total++;
    if ({oc, od} !== {2'd0, 8'h00}) $display("FAIL sparse_out0 got c=%0d d=%h want c=0 d=00", oc, od); else passed++;
    total++;
    if (ready !== 4'b0100) $display("FAIL sparse_grant2 got %b want 0100", ready); else passed++;
    step();
    total++;
    if ({oc, od} !== {2'd2, 8'h02}) $display("FAIL sparse_out2 got c=%0d d=%h want c=2 d=02", oc, od); else passed++;
    valid = 4'h0;
    step();
  endtask

  task automatic test_unlocked;
    u_data = 32'h0000B0A0; u_last = 4'b0000; u_valid = 4'b0011;
    step();
    total++;
    if ({u_ov, u_oc, u_od, u_ol} !== {1'b1, 2'd0, 8'hA0, 1'b0}) $display("FAIL ul_beat0 got v=%b c=%0d d=%h l=%b want v=1 c=0 d=a0 l=0", u_ov, u_oc, u_od, u_ol); else passed++;
    total++;
    if (u_ready !== 4'b0010) $display("FAIL ul_ready got %b want 0010", u_ready); else passed++;
    u_data = 32'h0000B0A1; u_last = 4'b0001;
    step();
    total++;
    if ({u_oc, u_od, u_ol} !== {2'd1, 8'hB0, 1'b0}) $display("FAIL ul_beat1 got c=%0d d=%h l=%b want c=1 d=b0 l=0", u_oc, u_od, u_ol); else passed++;
    u_data = 32'h0000B1A1; u_last = 4'b0011;
    step();
    total++;
    if ({u_oc, u_od, u_ol} !== {2'd0, 8'hA1, 1'b1}) $display("FAIL ul_beat2 got c=%0d d=%h l=%b want c=0 d=a1 l=1", u_oc, u_od, u_ol); else passed++;
    u_valid = 4'b0010;
    step();
    total++;
    if ({u_oc, u_od, u_ol} !== {2'd1, 8'hB1, 1'b1}) $display("FAIL ul_beat3 got c=%0d d=%h l=%b want c=1 d=b1 l=1", u_oc, u_od, u_ol); else passed++;
    u_valid = 4'h0;
    step();
    total++;
    if (u_ov !== 1'b0) $display("FAIL ul_drain got %b want 0", u_ov); else passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_sparse();
    test_unlocked();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/round_robin_stream_arbiter.md
Name: round_robin_stream_arbiter

Overview:
- N-input to 1-output valid/ready stream multiplexer, arbitrated by a round-robin pointer.
- Sits directly downstream of the request sources: consumes per-channel requests (input_valid), produces the grant internally, and forwards the winning channel's data beats through a registered output stage.
- Optional packet locking holds the grant on one channel from first beat until last beat, so packets never interleave.

Parameters:
- CHANNELS, 4: number of input channels (>=2).
- WIDTH, 8: data width per beat.
- LOCK_PACKETS, 1: 1 = hold grant until input_last beat accepted; 0 = re-arbitrate after every beat (input_last is forwarded only).

Ports:
- clock  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- input_valid  input  CHANNELS  per-channel beat valid (arbitration request).
- input_ready  output  CHANNELS  per-channel ready, at most one bit set.
- input_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- input_last  input  CHANNELS  per-channel end-of-packet flag.
- output_valid  output  1  registered output beat valid.
- output_ready  input  1  downstream ready.
- output_data  output  WIDTH  registered beat data.
- output_last  output  1  registered end-of-packet flag.
- output_channel  output  max(1,$clog2(CHANNELS))  source channel index of the current output beat.

Behaviour:
- Reset (reset=1 at a rising edge):
  - output_valid=0, output_data=0, output_last=0, output_channel=0.
  - Pointer=0, state=IDLE.
  - input_ready=0 whenever reset is high.
  - Reset mid-packet discards the lock and any held output beat.
- Output stage can_load = !output_valid || output_ready (single register; full throughput with downstream ready high).
- IDLE:
  - Grant g = first channel with input_valid=1, searching from pointer upward and wrapping at CHANNELS-1 -> 0.
  - input_ready[g] = can_load; all other input_ready bits = 0.
  - No valid channel -> no grant, input_ready=0.
- LOCKED:
  - Grant fixed to the locked channel, regardless of other requests or that channel's input_valid.
  - input_ready[locked] = can_load; all other bits = 0.
- Transfer occurs when input_valid[g] && input_ready[g]. At the next edge: output_valid=1, output_data/output_last/output_channel loaded from channel g.
- Latency: exactly 1 cycle from input handshake to output_valid.
- output_valid && !output_ready: output registers hold all values; input_ready=0 for every channel.
- Output beat completes without a new load: output_valid=0 at the next edge; data fields hold their previous value.
- State transitions (LOCK_PACKETS=1):
  - IDLE -> LOCKED on transfer with input_last=0.
  - LOCKED -> IDLE on transfer with input_last=1.
  - IDLE stays IDLE on transfer with input_last=1 (single-beat packet).
- Pointer update:
  - On the last beat (LOCK_PACKETS=1) or on every beat (LOCK_PACKETS=0), pointer = g+1, wrapping CHANNELS-1 -> 0.
  - No transfer -> pointer unchanged, including when grant is computed but blocked by backpressure.
- LOCK_PACKETS=0: state never leaves IDLE.
- Grant stability: a granted channel whose beat is blocked by backpressure stays granted in the next cycle if still valid and no lower-distance channel has appeared. Transfer fairness is guaranteed by pointer advance only after transfer.
- Starvation bound: with all channels continuously requesting single-beat packets, each channel gets one beat per CHANNELS transfers.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with all input_valid=1 -> input_ready=0000, output_valid=0, output_data=0. After release, first grant is channel 0.
- All channels valid, single-beat packets, output_ready=1, data = channel index -> output_channel sequence 0,1,2,3,0,1,… one beat per cycle; output_data matches channel, 1-cycle latency.
- Packet lock: channel 1 sends a 3-beat packet (last on beat 3) while channels 0,2,3 are valid -> output_channel=1 for 3 consecutive beats, no interleave; next grant is channel 2.
- Backpressure: output_ready=0 for 5 cycles with output_valid=1 -> output_data/last/channel stable, input_ready=0000, pointer unchanged. Releasing output_ready resumes the correct sequence with no lost or duplicated beats.
- Sparse requests: only channel 3 valid, pointer=0 -> grant 3; pointer becomes 0 (wrap); then channels 0 and 2 valid -> channel 0 first, then 2.
- LOCK_PACKETS=0 with 2-beat packets on channels 0 and 1 -> beats interleave 0,1,0,1; output_last forwarded unchanged per beat.
